// File: rtl/tic_tac_toe_move_ctrl.sv
// rtl/tic_tac_toe_move_ctrl.sv - player button / cell-select input stage for the tic-tac-toe core
//
// Purpose:
//   Turns raw, bouncing player pushbuttons and a 4-bit cell select into clean,
//   turn-ordered move strobes for the game core. It reads the core's
//   illegal_move / winner feedback after each move to decide whose turn is
//   next, or to freeze play until reset.
//
// Ports:
//   clk           system clock, all state on rising edge
//   reset         asynchronous active-low reset
//   btn_p1/btn_p2 raw asynchronous player buttons (may bounce)
//   sel_pos[3:0]  cell select, 0..8 valid, sampled when a move is accepted
//   illegal_move  core feedback: last move rejected
//   winner[1:0]   core feedback: nonzero once the game is decided
//   p1/p2         move strobes, held STROBE_CYCLES cycles, never both high
//   p1_pos/p2_pos cell of the last accepted move of each player
//   turn          0 = player 1 to move, 1 = player 2 to move
//   game_over     high once a winner has been seen, until reset
//   bad_sel       one-cycle pulse when the current player presses with sel_pos > 8
module tic_tac_toe_move_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int STROBE_CYCLES   = 2,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_p1,
  input  logic       btn_p2,
  input  logic [3:0] sel_pos,
  input  logic       illegal_move,
  input  logic [1:0] winner,
  output logic       p1,
  output logic       p2,
  output logic [3:0] p1_pos,
  output logic [3:0] p2_pos,
  output logic       turn,
  output logic       game_over,
  output logic       bad_sel
);

  localparam int CW   = $clog2(DEBOUNCE_CYCLES);
  localparam int TMAX = (STROBE_CYCLES > SETTLE_CYCLES) ? STROBE_CYCLES : SETTLE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STROBE_CYCLES - 1);
  localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_MOVE,
    ISSUE,
    SETTLE,
    OVER
  } state_t;

  // Button conditioning, index 0 = player 1, index 1 = player 2.
  logic [1:0]         btn_raw;
  logic [1:0]         sync1_q;
  logic [1:0]         sync2_q;
  logic [1:0]         db_q;
  logic [1:0]         db_dly_q;
  logic [1:0]         press_q;
  logic [1:0][CW-1:0] cnt_q;

  assign btn_raw = {btn_p2, btn_p1};

  // Press events are taken from a registered rising edge of the debounced
  // level. That keeps the decision path into the FSM free of the counter
  // compare logic. Releases are ignored. The counters keep running in every
  // FSM state, so a held button yields exactly one event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      press_q  <= '0;
      cnt_q    <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        sync1_q[i]  <= btn_raw[i];
        sync2_q[i]  <= sync1_q[i];
        db_dly_q[i] <= db_q[i];
        press_q[i]  <= db_q[i] & ~db_dly_q[i];
        if (sync2_q[i] == db_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DB_LAST) begin
          db_q[i]  <= ~db_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Move sequencing
  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          turn_q, turn_d;
  logic [3:0]    p1_pos_q, p1_pos_d;
  logic [3:0]    p2_pos_q, p2_pos_d;
  logic          press_cur;

  // Only the player whose turn it is can be heard; the other press is dropped.
  assign press_cur = turn_q ? press_q[1] : press_q[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= WAIT_MOVE;
      tmr_q    <= '0;
      turn_q   <= 1'b0;
      p1_pos_q <= '0;
      p2_pos_q <= '0;
    end else begin
      state_q  <= state_d;
      tmr_q    <= tmr_d;
      turn_q   <= turn_d;
      p1_pos_q <= p1_pos_d;
      p2_pos_q <= p2_pos_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    turn_d    = turn_q;
    p1_pos_d  = p1_pos_q;
    p2_pos_d  = p2_pos_q;
    p1        = 1'b0;
    p2        = 1'b0;
    bad_sel   = 1'b0;
    game_over = 1'b0;
    case (state_q)
      WAIT_MOVE: begin
        if (press_cur) begin
          if (sel_pos > 4'd8) begin
            bad_sel = 1'b1;
          end else begin
            if (turn_q) p2_pos_d = sel_pos;
            else        p1_pos_d = sel_pos;
            tmr_d   = '0;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        p1 = ~turn_q;
        p2 = turn_q;
        if (tmr_q == STB_LAST) begin
          tmr_d   = '0;
          state_d = SETTLE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      SETTLE: begin
        // Core feedback is only trusted on the last settle cycle; a win
        // outranks an illegal-move report.
        if (tmr_q == SET_LAST) begin
          tmr_d = '0;
          if (winner != 2'b00) begin
            state_d = OVER;
          end else begin
            state_d = WAIT_MOVE;
            if (!illegal_move) turn_d = ~turn_q;
          end
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      OVER: begin
        game_over = 1'b1;
      end
      default: begin
        state_d = WAIT_MOVE;
      end
    endcase
  end

  assign p1_pos = p1_pos_q;
  assign p2_pos = p2_pos_q;
  assign turn   = turn_q;

endmodule

// File: tb/tb_tic_tac_toe_move_ctrl.sv
// tb/tb_tic_tac_toe_move_ctrl.sv - self-checking bench for tic_tac_toe_move_ctrl
module tb_tic_tac_toe_move_ctrl;

  localparam int DEB = 4;
  localparam int STB = 2;
  localparam int SET = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_p1 = 1'b0;
  logic       btn_p2 = 1'b0;
  logic [3:0] sel_pos = 4'd0;
  logic       illegal_move = 1'b0;
  logic [1:0] winner = 2'b00;
  logic       p1, p2, turn, game_over, bad_sel;
  logic [3:0] p1_pos, p2_pos;

  tic_tac_toe_move_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .STROBE_CYCLES  (STB),
    .SETTLE_CYCLES  (SET)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_p1      (btn_p1),
    .btn_p2      (btn_p2),
    .sel_pos     (sel_pos),
    .illegal_move(illegal_move),
    .winner      (winner),
    .p1          (p1),
    .p2          (p2),
    .p1_pos      (p1_pos),
    .p2_pos      (p2_pos),
    .turn        (turn),
    .game_over   (game_over),
    .bad_sel     (bad_sel)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Observation counters, sampled on the falling edge
  int cyc = 0;
  int p1_hi = 0, p2_hi = 0, p1_rise = 0, p2_rise = 0, bad_hi = 0, both_hi = 0;
  int first_p1 = -1, first_p2 = -1;
  logic p1_prev = 1'b0, p2_prev = 1'b0;
  logic [3:0] p1_pos_seen = 4'd0, p2_pos_seen = 4'd0;
  int press_c0 = 0;

  always @(negedge clk) begin
    cyc++;
    if (p1 === 1'b1) begin
      p1_hi++;
      p1_pos_seen = p1_pos;
      if (p1_prev !== 1'b1) begin
        p1_rise++;
        if (first_p1 < 0) first_p1 = cyc;
      end
    end
    if (p2 === 1'b1) begin
      p2_hi++;
      p2_pos_seen = p2_pos;
      if (p2_prev !== 1'b1) begin
        p2_rise++;
        if (first_p2 < 0) first_p2 = cyc;
      end
    end
    if (p1 === 1'b1 && p2 === 1'b1) both_hi++;
    if (bad_sel === 1'b1) bad_hi++;
    p1_prev = p1;
    p2_prev = p2;
  end

  // Reference model: game-level view of whose turn it is and what was played
  logic       m_turn;
  logic       m_over;
  logic [3:0] m_p1_pos, m_p2_pos;

  task automatic clear_mon();
    p1_hi = 0; p2_hi = 0; p1_rise = 0; p2_rise = 0; bad_hi = 0;
    first_p1 = -1; first_p2 = -1;
  endtask

  task automatic apply_reset();
    @(negedge clk); #1;
    reset = 1'b0; btn_p1 = 1'b0; btn_p2 = 1'b0; illegal_move = 1'b0; winner = 2'b00;
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    m_turn = 1'b0; m_over = 1'b0; m_p1_pos = 4'd0; m_p2_pos = 4'd0;
  endtask

  // which: 1 = player 1, 2 = player 2, 3 = both in the same cycle
  task automatic run_press(input int which, input logic [3:0] sel, input int bounce);
    clear_mon();
    @(negedge clk); #1;
    sel_pos = sel;
    for (int k = 0; k < bounce; k++) begin
      if (which != 2) btn_p1 = ~k[0];
      if (which != 1) btn_p2 = ~k[0];
      @(negedge clk); #1;
    end
    press_c0 = cyc;
    if (which != 2) btn_p1 = 1'b1;
    if (which != 1) btn_p2 = 1'b1;
    repeat (DEB + STB + SET + 8) @(negedge clk);
    #1;
    btn_p1 = 1'b0;
    btn_p2 = 1'b0;
    repeat (DEB + 6) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); #1;
      btn_p1 = 1'($urandom); btn_p2 = 1'($urandom); sel_pos = 4'($urandom);
      #1;
      checks++;
      if ({p1, p2, p1_pos, p2_pos, turn, game_over, bad_sel} !== 13'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%b exp=0", {p1, p2, p1_pos, p2_pos, turn, game_over, bad_sel});
      end
    end
    btn_p1 = 1'b0; btn_p2 = 1'b0; sel_pos = 4'd0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    #1;
    checks++;
    if ({p1, p2, turn, game_over, bad_sel} !== 5'd0) begin
      failures++;
      $display("FAIL reset_release got=%b exp=0", {p1, p2, turn, game_over, bad_sel});
    end
    m_turn = 1'b0; m_over = 1'b0; m_p1_pos = 4'd0; m_p2_pos = 4'd0;
  endtask

  task automatic test_clean_press();
    apply_reset();
    run_press(1, 4'd4, 0);
    checks++;
    if (first_p1 != press_c0 + DEB + 4) begin
      failures++; $display("FAIL clean_latency got=%0d exp=%0d", first_p1 - press_c0, DEB + 4);
    end
    checks++;
    if (p1_hi != STB || p2_hi != 0) begin
      failures++; $display("FAIL clean_strobe p1_hi=%0d p2_hi=%0d exp=%0d/0", p1_hi, p2_hi, STB);
    end
    checks++;
    if (p1_pos_seen !== 4'd4 || p1_pos !== 4'd4) begin
      failures++; $display("FAIL clean_pos got=%0d/%0d exp=4", p1_pos_seen, p1_pos);
    end
    checks++;
    if (turn !== 1'b1) begin
      failures++; $display("FAIL clean_turn got=%b exp=1", turn);
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    run_press(1, 4'd3, 10);
    checks++;
    if (p1_rise != 1 || p1_hi != STB) begin
      failures++; $display("FAIL bounce_strobes rises=%0d hi=%0d exp=1/%0d", p1_rise, p1_hi, STB);
    end
    checks++;
    if (turn !== 1'b1) begin
      failures++; $display("FAIL bounce_turn got=%b exp=1", turn);
    end
  endtask

  task automatic test_order();
    apply_reset();
    run_press(2, 4'd5, 0);
    checks++;
    if (p1_rise != 0 || p2_rise != 0 || turn !== 1'b0) begin
      failures++; $display("FAIL order_wrong_player p1=%0d p2=%0d turn=%b exp=0/0/0", p1_rise, p2_rise, turn);
    end
    run_press(3, 4'd6, 0);
    checks++;
    if (p1_rise != 1 || p2_rise != 0) begin
      failures++; $display("FAIL order_both p1=%0d p2=%0d exp=1/0", p1_rise, p2_rise);
    end
    checks++;
    if (p1_pos !== 4'd6 || turn !== 1'b1) begin
      failures++; $display("FAIL order_both_state pos=%0d turn=%b exp=6/1", p1_pos, turn);
    end
  endtask

  task automatic test_bad_sel_illegal();
    apply_reset();
    run_press(1, 4'd9, 0);
    checks++;
    if (bad_hi != 1) begin
      failures++; $display("FAIL bad_sel_pulse got=%0d cycles exp=1", bad_hi);
    end
    checks++;
    if (p1_rise != 0 || p2_rise != 0 || turn !== 1'b0 || p1_pos !== 4'd0) begin
      failures++; $display("FAIL bad_sel_effect p1=%0d p2=%0d turn=%b pos=%0d exp=0/0/0/0", p1_rise, p2_rise, turn, p1_pos);
    end
    illegal_move = 1'b1;
    run_press(1, 4'd2, 0);
    illegal_move = 1'b0;
    checks++;
    if (p1_rise != 1 || p1_pos !== 4'd2 || turn !== 1'b0) begin
      failures++; $display("FAIL illegal_retry p1=%0d pos=%0d turn=%b exp=1/2/0", p1_rise, p1_pos, turn);
    end
  endtask

  task automatic test_winner();
    apply_reset();
    winner = 2'b01;
    run_press(1, 4'd7, 0);
    checks++;
    if (p1_rise != 1 || game_over !== 1'b1) begin
      failures++; $display("FAIL winner_over p1=%0d game_over=%b exp=1/1", p1_rise, game_over);
    end
    winner = 2'b00;
    run_press(1, 4'd1, 0);
    run_press(2, 4'd1, 0);
    checks++;
    if (p1_rise != 0 || p2_rise != 0 || game_over !== 1'b1 || p1_pos !== 4'd7) begin
      failures++; $display("FAIL winner_frozen p1=%0d p2=%0d over=%b pos=%0d exp=0/0/1/7", p1_rise, p2_rise, game_over, p1_pos);
    end
    apply_reset();
    checks++;
    if ({p1, p2, p1_pos, p2_pos, turn, game_over, bad_sel} !== 13'd0) begin
      failures++; $display("FAIL winner_reset got=%b exp=0", {p1, p2, p1_pos, p2_pos, turn, game_over, bad_sel});
    end
  endtask

  task automatic test_reset_mid_strobe();
    int seen;
    apply_reset();
    @(negedge clk); #1;
    sel_pos = 4'd5;
    btn_p1 = 1'b1;
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (p1 === 1'b1) seen = 1;
    end
    checks++;
    if (seen == 0) begin
      failures++; $display("FAIL mid_strobe_timeout got=no strobe exp=strobe within 20 cycles");
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (p1 !== 1'b0 || turn !== 1'b0 || p1_pos !== 4'd0) begin
      failures++; $display("FAIL mid_strobe_async p1=%b turn=%b pos=%0d exp=0/0/0", p1, turn, p1_pos);
    end
    btn_p1 = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    repeat (DEB + 6) @(negedge clk);
    m_turn = 1'b0; m_over = 1'b0; m_p1_pos = 4'd0; m_p2_pos = 4'd0;
  endtask

  task automatic test_random();
    int which, bounce, exp_p1, exp_p2, exp_bad;
    logic [3:0] sel;
    logic acc, ill;
    logic [1:0] win;
    apply_reset();
    for (int r = 0; r < 30; r++) begin
      which  = int'($urandom_range(1, 3));
      sel    = 4'($urandom_range(0, 11));
      bounce = 2 * int'($urandom_range(0, 3));
      ill    = ($urandom_range(0, 2) == 0);
      win    = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      illegal_move = ill;
      winner = win;
      acc = !m_over && (which == 3 || (which == 1 && !m_turn) || (which == 2 && m_turn));
      exp_p1 = 0; exp_p2 = 0; exp_bad = 0;
      if (acc && sel > 4'd8) begin
        exp_bad = 1;
      end else if (acc) begin
        if (m_turn) begin exp_p2 = STB; m_p2_pos = sel; end
        else        begin exp_p1 = STB; m_p1_pos = sel; end
        if (win != 2'b00) m_over = 1'b1;
        else if (!ill)    m_turn = ~m_turn;
      end
      run_press(which, sel, bounce);
      checks++;
      if (p1_hi != exp_p1 || p2_hi != exp_p2 || bad_hi != exp_bad) begin
        failures++;
        $display("FAIL rnd_outputs r=%0d p1_hi=%0d p2_hi=%0d bad=%0d exp=%0d/%0d/%0d", r, p1_hi, p2_hi, bad_hi, exp_p1, exp_p2, exp_bad);
      end
      checks++;
      if (turn !== m_turn || game_over !== m_over || p1_pos !== m_p1_pos || p2_pos !== m_p2_pos) begin
        failures++;
        $display("FAIL rnd_state r=%0d turn=%b over=%b pos=%0d/%0d exp=%b/%b/%0d/%0d", r, turn, game_over, p1_pos, p2_pos, m_turn, m_over, m_p1_pos, m_p2_pos);
      end
      if (exp_p1 != 0) begin
        checks++;
        if (first_p1 != press_c0 + DEB + 4 || p1_pos_seen !== sel) begin
          failures++; $display("FAIL rnd_p1_timing r=%0d lat=%0d pos=%0d exp=%0d/%0d", r, first_p1 - press_c0, p1_pos_seen, DEB + 4, sel);
        end
      end
      if (exp_p2 != 0) begin
        checks++;
        if (first_p2 != press_c0 + DEB + 4 || p2_pos_seen !== sel) begin
          failures++; $display("FAIL rnd_p2_timing r=%0d lat=%0d pos=%0d exp=%0d/%0d", r, first_p2 - press_c0, p2_pos_seen, DEB + 4, sel);
        end
      end
      if (m_over) apply_reset();
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (both_hi != 0) begin
      failures++; $display("FAIL strobe_overlap got=%0d cycles exp=0", both_hi);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_order();
    test_bad_sel_illegal();
    test_winner();
    test_reset_mid_strobe();
    test_random();
    test_no_overlap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
